// File: rtl/sr04_pkg.sv
// Shared types and defaults for the SR04 ranging controller.
package sr04_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    localparam int DEF_TRIG_CYCLES         = 1000;
    localparam int DEF_ECHO_TIMEOUT_CYCLES = 3_000_000;
    localparam int DEF_MAX_ECHO_CYCLES     = 2_500_000;
    localparam int DEF_PERIOD_CYCLES       = 6_000_000;
    localparam int DEF_CNT_W               = 23;

    // The period must hold a full trigger + worst-case wait + saturated echo, and fit the counters.
    function automatic bit timing_fits(input int trig_c, input int timeout_c, input int max_echo_c,
                                       input int period_c, input int cnt_w);
        longint lim;
        lim = longint'(1) << cnt_w;
        return (trig_c > 0) && (timeout_c > 0) && (max_echo_c > 0)
            && (longint'(period_c) > longint'(trig_c) + longint'(timeout_c) + longint'(max_echo_c) + 8)
            && (longint'(period_c) < lim);
    endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the raw sensor echo plus registered-copy edge detect.
// Latency: echo_s two edges after the input; rise/fall decode echo_s against its one-cycle-old copy.
module echo_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic echo_raw,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic echo_meta;
    logic echo_d;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo_raw;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

endmodule

// File: rtl/sr04_ranging_ctrl.sv
// Periodic trigger/echo ranging controller; free-running while enabled, no backpressure on outputs.
// Latency: trig/busy one clock after the FSM leaves IDLE; echo_win 3 clocks after raw echo; strobes 1 clock after exit.
module sr04_ranging_ctrl
    import sr04_pkg::*;
#(
    parameter int TRIG_CYCLES         = DEF_TRIG_CYCLES,
    parameter int ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
    parameter int MAX_ECHO_CYCLES     = DEF_MAX_ECHO_CYCLES,
    parameter int PERIOD_CYCLES       = DEF_PERIOD_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             time_echo,
    output logic             trig,
    output logic             echo_win,
    output logic [CNT_W-1:0] echo_cycles,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    if (!timing_fits(TRIG_CYCLES, ECHO_TIMEOUT_CYCLES, MAX_ECHO_CYCLES, PERIOD_CYCLES, CNT_W)) begin : g_bad_timing
        $error("sr04_ranging_ctrl: PERIOD_CYCLES must exceed TRIG+ECHO_TIMEOUT+MAX_ECHO+8 and fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX    = CNT_W'(MAX_ECHO_CYCLES);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_SAT     = '1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] width_cnt;
    logic             echo_s;
    logic             rise;
    logic             fall;
    logic             trig_nxt;
    logic             busy_nxt;
    logic             meas_vld_nxt;
    logic             timeout_nxt;

    echo_sync u_echo_sync (
        .clk_in   (clk_in),
        .rst      (rst),
        .echo_raw (time_echo),
        .echo_s   (echo_s),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // TRIG spends its first cycle arming the registered trig, then TRIG_CYCLES with trig high.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (enable) state_nxt = S_TRIG;
            S_TRIG:      if (phase_cnt == TRIG_LAST) state_nxt = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (rise)                         state_nxt = S_MEASURE;
                else if (phase_cnt == WAIT_LAST)  state_nxt = S_HOLDOFF;
            end
            S_MEASURE:   if (fall || (width_cnt == ECHO_MAX)) state_nxt = S_HOLDOFF;
            S_HOLDOFF:   if (period_cnt >= PERIOD_LAST) state_nxt = enable ? S_TRIG : S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // echo_win covers the fall-detect cycle too, so its high time equals the reported width.
    always_comb begin
        echo_win     = (state == S_MEASURE);
        trig_nxt     = (state == S_TRIG) && (state_nxt == S_TRIG);
        busy_nxt     = (state != S_IDLE);
        meas_vld_nxt = (state == S_MEASURE) && fall;
        timeout_nxt  = ((state == S_WAIT_RISE) && !rise && (phase_cnt == WAIT_LAST))
                    || ((state == S_MEASURE) && !fall && (width_cnt == ECHO_MAX));
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            trig        <= 1'b0;
            busy        <= 1'b0;
            meas_valid  <= 1'b0;
            timeout     <= 1'b0;
            echo_cycles <= '0;
            period_cnt  <= '0;
            phase_cnt   <= '0;
            width_cnt   <= '0;
        end else begin
            trig       <= trig_nxt;
            busy       <= busy_nxt;
            meas_valid <= meas_vld_nxt;
            timeout    <= timeout_nxt;

            if ((state_nxt == S_TRIG) && (state != S_TRIG))
                period_cnt <= '0;
            else if ((state != S_IDLE) && (period_cnt != CNT_SAT))
                period_cnt <= period_cnt + CNT_ONE;

            if (state_nxt != state)
                phase_cnt <= '0;
            else if ((state == S_TRIG) || (state == S_WAIT_RISE))
                phase_cnt <= phase_cnt + CNT_ONE;

            if ((state == S_WAIT_RISE) && rise)
                width_cnt <= CNT_ONE;
            else if ((state == S_MEASURE) && echo_s && (width_cnt != ECHO_MAX))
                width_cnt <= width_cnt + CNT_ONE;

            if (state == S_MEASURE) begin
                if (fall)                        echo_cycles <= width_cnt;
                else if (width_cnt == ECHO_MAX)  echo_cycles <= ECHO_MAX;
            end
        end
    end

endmodule

// File: tb/tb_sr04_ranging_ctrl.sv
// Self-checking bench for sr04_ranging_ctrl: vector table, randomized periods and hand-written corner cases.
module tb_sr04_ranging_ctrl;

    localparam int T  = 10;
    localparam int TO = 50;
    localparam int MX = 100;
    localparam int P  = 300;
    localparam int W  = 23;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         time_echo = 1'b0;
    logic         trig;
    logic         echo_win;
    logic [W-1:0] echo_cycles;
    logic         meas_valid;
    logic         timeout;
    logic         busy;

    sr04_ranging_ctrl #(
        .TRIG_CYCLES(T), .ECHO_TIMEOUT_CYCLES(TO), .MAX_ECHO_CYCLES(MX),
        .PERIOD_CYCLES(P), .CNT_W(W)
    ) dut (
        .clk_in(clk_in), .rst(rst), .enable(enable), .time_echo(time_echo),
        .trig(trig), .echo_win(echo_win), .echo_cycles(echo_cycles),
        .meas_valid(meas_valid), .timeout(timeout), .busy(busy)
    );

    initial forever #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Event monitor: cumulative counts and cycle stamps of output activity.
    int trig_rises = 0, last_rise = 0, last_fall = 0, trig_len = 0, trig_len_cur = 0;
    int win_total = 0, win_rise = 0, win_last = 0;
    int mv_total = 0, mv_cyc = 0, to_total = 0, to_cyc = 0, strobe_err = 0, busy_fall = 0;
    logic [W-1:0] mv_val = '0;
    bit trig_q = 0, win_q = 0, strobe_q = 0, busy_q = 0;

    always @(negedge clk_in) begin
        if (rst) begin
            trig_q <= 0; win_q <= 0; strobe_q <= 0; busy_q <= 0;
        end else begin
            trig_q   <= trig;
            win_q    <= echo_win;
            busy_q   <= busy;
            strobe_q <= meas_valid | timeout;
            if (trig && !trig_q) begin trig_rises <= trig_rises + 1; last_rise <= cyc; end
            if (trig) trig_len_cur <= (trig_q ? trig_len_cur : 0) + 1;
            if (!trig && trig_q) begin last_fall <= cyc; trig_len <= trig_len_cur; end
            if (echo_win) begin
                win_total <= win_total + 1;
                win_last  <= cyc;
                if (!win_q) win_rise <= cyc;
            end
            if (meas_valid) begin mv_total <= mv_total + 1; mv_cyc <= cyc; mv_val <= echo_cycles; end
            if (timeout) begin to_total <= to_total + 1; to_cyc <= cyc; end
            if ((meas_valid || timeout) && (strobe_q || (meas_valid && timeout))) strobe_err <= strobe_err + 1;
            if (!busy && busy_q) busy_fall <= cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #2;
    endtask

    // Reference model: outcome of one period from the raw echo width alone (0 = no echo).
    function automatic void model(input int w, input int prev_ec, output int e_win,
                                  output bit e_mv, output bit e_to, output int e_ec);
        if (w == 0) begin
            e_win = 0; e_mv = 0; e_to = 1; e_ec = prev_ec;
        end else if (w <= MX) begin
            e_win = w; e_mv = 1; e_to = 0; e_ec = w;
        end else begin
            e_win = MX; e_mv = 0; e_to = 1; e_ec = MX;
        end
    endfunction

    int rises_seen = 0;
    int prev_rise  = -1;

    task automatic do_period(input int id, input int d, input int w, input bit stale, input bit drop_en,
                             input int e_win, input bit e_mv, input bit e_to, input int e_ec);
        int r_cyc, win0, mv0, to0, c_on;
        bit ok;
        if (stale) time_echo = 1'b1;
        ok = 0;
        for (int i = 0; i < P + 20; i++) begin
            if (trig_rises > rises_seen) begin ok = 1; break; end
            tick();
        end
        check($sformatf("p%0d_trig_rise_seen", id), ok, 1);
        if (!ok) return;
        rises_seen = trig_rises;
        r_cyc = last_rise;
        if (prev_rise >= 0) check($sformatf("p%0d_period", id), r_cyc - prev_rise, P);
        prev_rise = r_cyc;
        win0 = win_total; mv0 = mv_total; to0 = to_total;
        for (int i = 0; i < T + 10 && trig; i++) tick();
        check($sformatf("p%0d_trig_fell", id), trig, 0);
        check($sformatf("p%0d_trig_len", id), trig_len, T);
        for (int i = 0; i < d; i++) tick();
        c_on = 0;
        if (w > 0) begin
            c_on = cyc;
            time_echo = 1'b1;
            for (int k = 0; k < w; k++) begin
                if (drop_en && k == 5) enable = 1'b0;
                tick();
            end
            time_echo = 1'b0;
        end
        while (cyc < r_cyc + P - 5) tick();
        check($sformatf("p%0d_win_cycles", id), win_total - win0, e_win);
        check($sformatf("p%0d_meas_valid_cnt", id), mv_total - mv0, e_mv);
        check($sformatf("p%0d_timeout_cnt", id), to_total - to0, e_to);
        check($sformatf("p%0d_echo_cycles", id), echo_cycles, e_ec);
        if (e_mv) begin
            check($sformatf("p%0d_mv_value", id), mv_val, e_ec);
            check($sformatf("p%0d_mv_after_win", id), mv_cyc - win_last, 1);
        end
        if (e_win > 0) check($sformatf("p%0d_win_rise_lat", id), win_rise - c_on, 3);
        if (e_to && e_win == 0) check($sformatf("p%0d_timeout_lat", id), to_cyc - last_fall, TO);
        if (stale) time_echo = 1'b0;
    endtask

    typedef struct {
        int d;
        int w;
        bit stale;
        int e_win;
        bit e_mv;
        bit e_to;
        int e_ec;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int k, ec_model;
        vecs[0] = '{d: 20, w: 40,  stale: 0, e_win: 40,  e_mv: 1, e_to: 0, e_ec: 40};
        vecs[1] = '{d: 0,  w: 0,   stale: 0, e_win: 0,   e_mv: 0, e_to: 1, e_ec: 40};
        vecs[2] = '{d: 0,  w: 0,   stale: 1, e_win: 0,   e_mv: 0, e_to: 1, e_ec: 40};
        vecs[3] = '{d: 5,  w: 30,  stale: 0, e_win: 30,  e_mv: 1, e_to: 0, e_ec: 30};
        vecs[4] = '{d: 10, w: 150, stale: 0, e_win: 100, e_mv: 0, e_to: 1, e_ec: 100};
        vecs[5] = '{d: 0,  w: 1,   stale: 0, e_win: 1,   e_mv: 1, e_to: 0, e_ec: 1};
        vecs[6] = '{d: 3,  w: 99,  stale: 0, e_win: 99,  e_mv: 1, e_to: 0, e_ec: 99};
        vecs[7] = '{d: 3,  w: 101, stale: 0, e_win: 100, e_mv: 0, e_to: 1, e_ec: 100};

        repeat (3) tick();
        check("rst_trig", trig, 0);
        check("rst_echo_win", echo_win, 0);
        check("rst_echo_cycles", echo_cycles, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (3) tick();

        enable = 1'b1;
        tick();
        check("start_trig_n1", trig, 0);
        check("start_busy_n1", busy, 0);
        tick();
        check("start_trig_n2", trig, 1);
        check("start_busy_n2", busy, 1);

        for (int i = 0; i < 8; i++)
            do_period(i, vecs[i].d, vecs[i].w, vecs[i].stale, 1'b0,
                      vecs[i].e_win, vecs[i].e_mv, vecs[i].e_to, vecs[i].e_ec);

        ec_model = vecs[7].e_ec;
        for (int i = 0; i < 10; i++) begin
            int d, w, ew, ec;
            bit mv, to;
            d = $urandom_range(0, TO - 6);
            w = $urandom_range(1, 160);
            if (w == MX) w = MX - 1;
            if ($urandom_range(0, 4) == 0) w = 0;
            model(w, ec_model, ew, mv, to, ec);
            do_period(100 + i, d, w, 1'b0, 1'b0, ew, mv, to, ec);
            ec_model = ec;
        end

        do_period(200, 10, 40, 1'b0, 1'b1, 40, 1'b1, 1'b0, 40);
        k = 0;
        while (busy && k < 40) begin tick(); k++; end
        check("drop_busy_low", busy, 0);
        check("drop_busy_fall_time", busy_fall - prev_rise, P);
        repeat (400) tick();
        check("drop_no_more_trig", trig_rises - rises_seen, 0);

        enable = 1'b1;
        k = 0;
        while (!trig && k < 10) begin tick(); k++; end
        check("rstmid_trig_before", trig, 1);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        check("rstmid_trig", trig, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_echo_cycles", echo_cycles, 0);
        check("rstmid_echo_win", echo_win, 0);
        check("rstmid_strobes", {meas_valid, timeout}, 0);
        enable = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (20) tick();
        check("rstmid_idle_trig", trig, 0);
        check("rstmid_idle_busy", busy, 0);
        enable = 1'b1;
        tick();
        check("rstmid_restart_n1", trig, 0);
        tick();
        check("rstmid_restart_n2", trig, 1);
        enable = 1'b0;

        check("strobe_exclusive_spacing", strobe_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sr04_ranging_ctrl.md
# sr04_ranging_ctrl

Initiator side of the ultrasonic ranging link on the miniCar: issues the trigger pulse to the HC-SR04-class sensor, waits for the echo, and measures the echo width in clock cycles. It repeats at a fixed period. Outputs are:
- a gated, synchronized echo window, which feeds the BCD distance counter;
- a binary width with a one-cycle valid strobe;
- a timeout strobe for obstacle-logic fallback.

## Interface
Parameters:
- TRIG_CYCLES, 1000, trigger high time in clocks (10 µs at 100 MHz)
- ECHO_TIMEOUT_CYCLES, 3_000_000, max wait for echo rise after trigger falls
- MAX_ECHO_CYCLES, 2_500_000, echo width saturation limit
- PERIOD_CYCLES, 6_000_000, trigger-rise to trigger-rise interval; must exceed TRIG_CYCLES + ECHO_TIMEOUT_CYCLES + MAX_ECHO_CYCLES + 8
- CNT_W, 23, width of all counters and echo_cycles

Ports:
- clk_in  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- enable  input  1  level; 1 = run periodic ranging
- time_echo  input  1  raw sensor echo, asynchronous
- trig  output  1  sensor trigger, registered
- echo_win  output  1  synchronized echo, gated to the MEASURE state
- echo_cycles  output  CNT_W  last completed echo width in clocks
- meas_valid  output  1  one-cycle strobe; echo_cycles updated
- timeout  output  1  one-cycle strobe; no echo, or echo saturated
- busy  output  1  high in every state except IDLE

## Operation
- Echo path: 2-flop synchronizer produces echo_s; a registered copy echo_d gives rise (echo_s & ~echo_d) and fall (~echo_s & echo_d).
- States: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE → TRIG when enable=1. Clear period_cnt and phase_cnt.
- TRIG:
  - trig=1 for exactly TRIG_CYCLES cycles, then → WAIT_RISE with phase_cnt cleared.
- WAIT_RISE:
  - rise → MEASURE, with width_cnt=1.
  - If phase_cnt reaches ECHO_TIMEOUT_CYCLES-1 first: pulse timeout, leave echo_cycles unchanged, → HOLDOFF.
  - Echo already high on entry is stale: ignored until a genuine rise.
- MEASURE:
  - echo_win=1.
  - width_cnt increments each cycle echo_s=1.
  - On fall: echo_cycles←width_cnt, pulse meas_valid, → HOLDOFF.
  - If width_cnt reaches MAX_ECHO_CYCLES: echo_cycles←MAX_ECHO_CYCLES, pulse timeout (not meas_valid), → HOLDOFF.
- HOLDOFF: wait until period_cnt = PERIOD_CYCLES-1, then → TRIG if enable, else → IDLE.
- period_cnt runs from TRIG entry through HOLDOFF and saturates; it never wraps.
- enable dropping mid-cycle: the current measurement completes normally; the block returns to IDLE at period end.
- meas_valid and timeout are mutually exclusive and never high in consecutive cycles.

## Timing
- Reset values: trig=0, echo_win=0, echo_cycles=0, meas_valid=0, timeout=0, busy=0, state=IDLE, all counters 0.
- Reset mid-operation: trig drops asynchronously; any pending strobe is lost.
- Trigger start: enable sampled high in IDLE at edge n → trig=1 and busy=1 after edge n+1.
- Trigger end: trig falls after edge n+1+TRIG_CYCLES.
- Echo window: echo_win rises 3 edges after the first edge sampling time_echo=1 (2 sync + state transition). It falls together with the MEASURE exit.
- echo_cycles equals the number of cycles echo_win was high. It is jitter-limited to ±1 versus the raw echo width.
- meas_valid asserts the cycle after echo_win falls; echo_cycles is stable from that cycle onward.
- Continuous enable: consecutive trig rises are exactly PERIOD_CYCLES apart.

## Structure
- Package sr04_pkg holds:
  - the state enum (3-bit encoding);
  - default parameter constants;
  - the derived timeout/period bounds check, an elaboration-time assertion.
- Sub-module echo_sync contains the 2-flop synchronizer plus edge detect (outputs echo_s, rise, fall), reset to 0.
- The FSM and counters live in the top.

## Test plan
All scenarios use TRIG_CYCLES=10, ECHO_TIMEOUT_CYCLES=50, MAX_ECHO_CYCLES=100, PERIOD_CYCLES=300.

- Normal echo: enable=1; echo rises 20 cycles after trig falls, high 40 cycles.
  - trig high 10 cycles.
  - echo_win high 40 cycles.
  - meas_valid one cycle, echo_cycles=40.
  - Next trig rise 300 cycles after the first.
- No echo: time_echo held 0.
  - timeout pulses 50 cycles after trig falls.
  - echo_cycles keeps its prior value; meas_valid never asserts.
- Stuck-high echo: time_echo held 1 before trigger.
  - No MEASURE entry; timeout after 50 cycles.
  - Release to 0, then a 30-cycle pulse in the next period → echo_cycles=30.
- Saturation: echo high 150 cycles.
  - echo_cycles=100, timeout pulse, no meas_valid.
  - echo_win low after 100 cycles.
- Enable drop and reset: enable=0 during MEASURE.
  - Measurement completes; busy falls at cycle 300; no further trig.
  - Assert rst during TRIG: all outputs 0 immediately, state IDLE.
